// File: rtl/seg7_bcd_counter_mux.sv
// Multi-digit BCD up/down counter driven by a programmable tick prescaler, with a
// time-multiplexed seven-segment scan driver for NDIGITS common-segment displays.

module seg7_bcd_digit (
    input  logic [3:0] digit,
    input  logic       dir,
    input  logic [3:0] load_nib,
    output logic [3:0] step_nib,
    output logic       sat,
    output logic [3:0] load_clamped,
    output logic [6:0] seg
);

    // sat marks the digit that passes a carry/borrow on when stepped
    always_comb begin
        sat      = dir ? (digit == 4'd9) : (digit == 4'd0);
        step_nib = digit;
        if (dir) begin
            step_nib = sat ? 4'd0 : digit + 4'd1;
        end else begin
            step_nib = sat ? 4'd9 : digit - 4'd1;
        end
    end

    assign load_clamped = (load_nib > 4'd9) ? 4'd9 : load_nib;

    always_comb begin
        seg = 7'h00;
        case (digit)
            4'd0: seg = 7'h3F;
            4'd1: seg = 7'h06;
            4'd2: seg = 7'h5B;
            4'd3: seg = 7'h4F;
            4'd4: seg = 7'h66;
            4'd5: seg = 7'h6D;
            4'd6: seg = 7'h7D;
            4'd7: seg = 7'h07;
            4'd8: seg = 7'h7F;
            4'd9: seg = 7'h6F;
            default: seg = 7'h00;
        endcase
    end

endmodule

module seg7_bcd_counter_mux #(
    parameter int NDIGITS     = 4,
    parameter int DIV_W       = 24,
    parameter int DEFAULT_DIV = 9_999_999,
    parameter int SCAN_W      = 10,
    parameter bit ACTIVE_LOW  = 1'b0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   count_en,
    input  logic                   dir,
    input  logic                   clear,
    input  logic                   load,
    input  logic [4*NDIGITS-1:0]   load_val,
    input  logic [DIV_W-1:0]       div_val,
    output logic                   tick,
    output logic                   wrap,
    output logic [4*NDIGITS-1:0]   bcd,
    output logic [6:0]             seg,
    output logic                   dp,
    output logic [NDIGITS-1:0]     dig_sel
);

    localparam int IDX_W = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;

    logic [DIV_W-1:0]             pre_q, pre_d, term;
    logic                         tick_q, tick_d;
    logic [NDIGITS-1:0][3:0]      bcd_q, bcd_d, step_nib, load_clamp;
    logic [NDIGITS-1:0][6:0]      dig_seg;
    logic [NDIGITS-1:0]           sat;
    logic [NDIGITS:0]             carry;
    logic                         wrap_q, wrap_d;
    logic [SCAN_W-1:0]            scan_q, scan_d;
    logic [IDX_W-1:0]             idx_q, idx_d;
    logic [NDIGITS-1:0]           dig_sel_q, dig_sel_d;
    logic [6:0]                   seg_q, seg_d;
    logic                         dp_q, dp_d;

    genvar g;
    generate
        for (g = 0; g < NDIGITS; g++) begin : g_digit
            seg7_bcd_digit u_digit (
                .digit        (bcd_q[g]),
                .dir          (dir),
                .load_nib     (load_val[4*g +: 4]),
                .step_nib     (step_nib[g]),
                .sat          (sat[g]),
                .load_clamped (load_clamp[g]),
                .seg          (dig_seg[g])
            );
        end
    endgenerate

    // Prescaler: '>=' so a div_val lowered below the running count ends the period at once
    always_comb begin
        term   = (div_val == '0) ? DIV_W'(DEFAULT_DIV) : div_val;
        pre_d  = pre_q;
        tick_d = 1'b0;
        if (count_en) begin
            if (pre_q >= term) begin
                pre_d  = '0;
                tick_d = 1'b1;
            end else begin
                pre_d  = pre_q + 1'b1;
            end
        end
    end

    // Carry chain: digit i steps only when every lower digit is saturated
    always_comb begin
        carry[0] = 1'b1;
        for (int i = 0; i < NDIGITS; i++) begin
            carry[i+1] = carry[i] & sat[i];
        end
    end

    always_comb begin
        bcd_d  = bcd_q;
        wrap_d = 1'b0;
        if (clear) begin
            bcd_d = '0;
        end else if (load) begin
            bcd_d = load_clamp;
        end else if (tick_q) begin
            for (int i = 0; i < NDIGITS; i++) begin
                if (carry[i]) begin
                    bcd_d[i] = step_nib[i];
                end
            end
            wrap_d = carry[NDIGITS];
        end
    end

    always_comb begin
        scan_d = scan_q + 1'b1;
        idx_d  = idx_q;
        if (scan_q == '1) begin
            idx_d = (idx_q == IDX_W'(NDIGITS - 1)) ? '0 : idx_q + 1'b1;
        end
    end

    // Output stage samples idx_q, so the display lags the scan index by one cycle
    always_comb begin
        dig_sel_d = NDIGITS'(1) << idx_q;
        seg_d     = dig_seg[idx_q];
        dp_d      = (idx_q == '0) && !count_en;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pre_q     <= '0;
            tick_q    <= 1'b0;
            bcd_q     <= '0;
            wrap_q    <= 1'b0;
            scan_q    <= '0;
            idx_q     <= '0;
            dig_sel_q <= '0;
            seg_q     <= '0;
            dp_q      <= 1'b0;
        end else begin
            pre_q     <= pre_d;
            tick_q    <= tick_d;
            bcd_q     <= bcd_d;
            wrap_q    <= wrap_d;
            scan_q    <= scan_d;
            idx_q     <= idx_d;
            dig_sel_q <= dig_sel_d;
            seg_q     <= seg_d;
            dp_q      <= dp_d;
        end
    end

    assign tick    = tick_q;
    assign wrap    = wrap_q;
    assign bcd     = bcd_q;
    assign seg     = ACTIVE_LOW ? ~seg_q     : seg_q;
    assign dp      = ACTIVE_LOW ? ~dp_q      : dp_q;
    assign dig_sel = ACTIVE_LOW ? ~dig_sel_q : dig_sel_q;

endmodule

// File: tb/tb_seg7_bcd_counter_mux.sv
// Bench for seg7_bcd_counter_mux: directed scenarios then random traffic, checked each
// cycle against an integer-valued model of count, prescaler period and scan position.

module tb_seg7_bcd_counter_mux;

    localparam int ND  = 4;
    localparam int DW  = 24;
    localparam int DEF = 20;
    localparam int SW  = 2;
    localparam int MOD = 10000;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          count_en = 1'b0;
    logic          dir = 1'b1;
    logic          clear = 1'b0;
    logic          load = 1'b0;
    logic [15:0]   load_val = '0;
    logic [DW-1:0] div_val = '0;

    logic tick_a, wrap_a, dp_a, tick_b, wrap_b, dp_b;
    logic [15:0] bcd_a, bcd_b;
    logic [6:0]  seg_a, seg_b;
    logic [3:0]  dig_a, dig_b;

    seg7_bcd_counter_mux #(.NDIGITS(ND), .DIV_W(DW), .DEFAULT_DIV(DEF), .SCAN_W(SW),
                           .ACTIVE_LOW(1'b0)) u_dut (
        .clk(clk), .reset(reset), .count_en(count_en), .dir(dir), .clear(clear),
        .load(load), .load_val(load_val), .div_val(div_val), .tick(tick_a),
        .wrap(wrap_a), .bcd(bcd_a), .seg(seg_a), .dp(dp_a), .dig_sel(dig_a));

    seg7_bcd_counter_mux #(.NDIGITS(ND), .DIV_W(DW), .DEFAULT_DIV(DEF), .SCAN_W(SW),
                           .ACTIVE_LOW(1'b1)) u_dut_n (
        .clk(clk), .reset(reset), .count_en(count_en), .dir(dir), .clear(clear),
        .load(load), .load_val(load_val), .div_val(div_val), .tick(tick_b),
        .wrap(wrap_b), .bcd(bcd_b), .seg(seg_b), .dp(dp_b), .dig_sel(dig_b));

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;

    // Model state: count kept as a plain integer, scan position derived from cycles since reset
    int         m_pre = 0, m_val = 0, m_cyc = 0;
    bit         m_tick = 0, m_wrap = 0, m_dp = 0;
    logic [6:0] m_seg = '0;
    logic [3:0] m_dig = '0;

    function automatic logic [6:0] segof(int d);
        case (d)
            0: return 7'h3F; 1: return 7'h06; 2: return 7'h5B; 3: return 7'h4F;
            4: return 7'h66; 5: return 7'h6D; 6: return 7'h7D; 7: return 7'h07;
            8: return 7'h7F; 9: return 7'h6F;
            default: return 7'h00;
        endcase
    endfunction

    function automatic int digit_of(int v, int i);
        return (v / (10 ** i)) % 10;
    endfunction

    function automatic logic [15:0] to_bcd(int v);
        logic [15:0] r;
        r = '0;
        for (int i = 0; i < ND; i++) r[4*i +: 4] = 4'(digit_of(v, i));
        return r;
    endfunction

    function automatic int clamp_val(logic [15:0] lv);
        int v, n;
        v = 0;
        for (int i = ND - 1; i >= 0; i--) begin
            n = int'(lv[4*i +: 4]);
            if (n > 9) n = 9;
            v = v * 10 + n;
        end
        return v;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_total = n_total + 1;
        assert (obs === exp) n_pass = n_pass + 1;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic check_all();
        logic [6:0] e_seg_n;
        logic [3:0] e_dig_n;
        logic       e_dp_n;
        e_seg_n = ~m_seg;
        e_dig_n = ~m_dig;
        e_dp_n  = ~m_dp;
        chk("bcd",     bcd_a,  to_bcd(m_val));
        chk("tick",    tick_a, m_tick);
        chk("wrap",    wrap_a, m_wrap);
        chk("seg",     seg_a,  m_seg);
        chk("dig_sel", dig_a,  m_dig);
        chk("dp",      dp_a,   m_dp);
        chk("bcd_n",   bcd_b,  to_bcd(m_val));
        chk("seg_n",   seg_b,  e_seg_n);
        chk("dig_n",   dig_b,  e_dig_n);
        chk("dp_n",    dp_b,   e_dp_n);
    endtask

    // One clock: model next state from the inputs currently applied, then compare
    task automatic cyc();
        int n_pre, n_val, n_cyc, idx, term;
        bit n_tick, n_wrap, n_dp;
        logic [6:0] n_seg;
        logic [3:0] n_dig;
        if (reset) begin
            n_pre = 0; n_val = 0; n_cyc = 0; n_tick = 0; n_wrap = 0;
            n_dp = 0; n_seg = '0; n_dig = '0;
        end else begin
            term   = (div_val == '0) ? DEF : int'(div_val);
            n_pre  = m_pre;
            n_tick = 0;
            if (count_en) begin
                if (m_pre >= term) begin n_pre = 0; n_tick = 1; end
                else n_pre = m_pre + 1;
            end
            n_val  = m_val;
            n_wrap = 0;
            if (clear) n_val = 0;
            else if (load) n_val = clamp_val(load_val);
            else if (m_tick) begin
                if (dir) begin n_wrap = (m_val == MOD - 1); n_val = (m_val + 1) % MOD; end
                else     begin n_wrap = (m_val == 0);       n_val = (m_val + MOD - 1) % MOD; end
            end
            idx   = (m_cyc >> SW) % ND;
            n_seg = segof(digit_of(m_val, idx));
            n_dig = 4'(1 << idx);
            n_dp  = (idx == 0) && !count_en;
            n_cyc = m_cyc + 1;
        end
        @(posedge clk);
        #1;
        m_pre = n_pre; m_val = n_val; m_cyc = n_cyc; m_tick = n_tick; m_wrap = n_wrap;
        m_dp = n_dp; m_seg = n_seg; m_dig = n_dig;
        check_all();
    endtask

    task automatic do_load(logic [15:0] v);
        count_en = 1'b0; load = 1'b1; load_val = v;
        cyc();
        load = 1'b0; count_en = 1'b1;
    endtask

    task automatic wait_change(int maxc);
        int v0;
        v0 = m_val;
        for (int i = 0; i < maxc && m_val == v0; i++) cyc();
    endtask

    initial begin
        int cnt [4];
        int gap;
        logic [6:0] e_seg;

        // Reset with the counter armed: first tick term+1 cycles after release
        reset = 1'b1; count_en = 1'b1; div_val = 24'd3; dir = 1'b1;
        repeat (3) cyc();
        reset = 1'b0;
        repeat (10) cyc();
        chk("t1_count", bcd_a, 16'h0002);

        // Carry across digits and up wrap
        div_val = 24'd1;
        do_load(16'h0099);
        wait_change(20);
        chk("t2_carry", bcd_a, 16'h0100);
        do_load(16'h9999);
        wait_change(20);
        chk("t2_wrap_val", bcd_a, 16'h0000);
        chk("t2_wrap", wrap_a, 1'b1);

        // Down wrap then plain borrow
        dir = 1'b0;
        do_load(16'h0000);
        wait_change(20);
        chk("t3_wrap_val", bcd_a, 16'h9999);
        chk("t3_wrap", wrap_a, 1'b1);
        wait_change(20);
        chk("t3_dec_val", bcd_a, 16'h9998);
        chk("t3_dec_wrap", wrap_a, 1'b0);

        // Clear, load and a pending tick in the same cycle
        div_val = 24'd2;
        for (int i = 0; i < 10 && !m_tick; i++) cyc();
        clear = 1'b1; load = 1'b1; load_val = 16'h1234;
        cyc();
        clear = 1'b0; load = 1'b0;
        chk("t4_clear", bcd_a, 16'h0000);
        chk("t4_nowrap", wrap_a, 1'b0);
        cyc();
        chk("t4_dropped", bcd_a, 16'h0000);

        // Scan with the counter frozen: 4-cycle dwell per digit, dp only on digit 0
        count_en = 1'b0; load = 1'b1; load_val = 16'h1234;
        cyc();
        load = 1'b0;
        cyc();
        for (int i = 0; i < 4; i++) cnt[i] = 0;
        for (int i = 0; i < 16; i++) begin
            cyc();
            case (dig_a)
                4'b0001: begin cnt[0]++; e_seg = 7'h66; end
                4'b0010: begin cnt[1]++; e_seg = 7'h4F; end
                4'b0100: begin cnt[2]++; e_seg = 7'h5B; end
                4'b1000: begin cnt[3]++; e_seg = 7'h06; end
                default: e_seg = 7'h00;
            endcase
            chk("t5_seg", seg_a, e_seg);
            chk("t5_dp", dp_a, dig_a == 4'b0001);
        end
        for (int i = 0; i < 4; i++) chk("t5_dwell", cnt[i], 4);

        // Default terminal count when div_val is zero
        clear = 1'b1; cyc(); clear = 1'b0;
        div_val = '0; count_en = 1'b1;
        for (int i = 0; i < 60 && !tick_a; i++) cyc();
        gap = 0;
        do begin cyc(); gap++; end while (!tick_a && gap < 60);
        chk("t6_period", gap, DEF + 1);

        // Random traffic including nibble clamping, mid-count reset and div changes
        repeat (1500) begin
            int r;
            r        = $urandom_range(0, 99);
            reset    = (r < 1);
            clear    = (r >= 1 && r < 3);
            load     = (r >= 3 && r < 7);
            count_en = ($urandom_range(0, 9) != 0);
            dir      = 1'($urandom_range(0, 1));
            load_val = 16'($urandom);
            div_val  = DW'($urandom_range(0, 4));
            cyc();
        end
        reset = 1'b0; clear = 1'b0; load = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
